branch_cmp_bht: RTL and testbench
=================================

Name: branch_cmp_bht

Overview:
- Decode-stage branch resolver with a bimodal branch history table (BHT).
- Resolves MIPS conditional branches (BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL) on WIDTH-bit operands.
- Provides a fetch-stage taken prediction from per-PC 2-bit saturating counters.
- Flags decode mispredictions and trains the table through a registered one-cycle update pipeline.

Parameters:
- WIDTH, 32, operand width of a_d/b_d.
- BHT_DEPTH, 64, number of 2-bit counters; power of two, minimum 4.
- IDX_W, log2(BHT_DEPTH), index width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- pc_f  in  32  fetch PC for lookup.
- pred_taken_f  out  1  prediction for pc_f.
- valid_d  in  1  decode instruction valid.
- stall_d  in  1  decode stalled; suppresses update and mispredict.
- flush_d  in  1  decode instruction squashed; same effect as stall_d.
- pc_d  in  32  decode PC.
- op_d  in  6  opcode field.
- rt_d  in  5  rt field (REGIMM subcode).
- a_d  in  WIDTH  rs operand, already forwarded.
- b_d  in  WIDTH  rt operand, already forwarded.
- pred_d  in  1  prediction carried from fetch for this instruction.
- is_branch_d  out  1  op/rt decodes to a conditional branch.
- taken_d  out  1  resolved condition.
- link_d  out  1  BLTZAL/BGEZAL; asserted regardless of taken.
- mispredict_d  out  1  valid_d & ~stall_d & ~flush_d & is_branch_d & (taken_d != pred_d).
- branch_cnt  out  32  resolved branches (optional feature).
- mispred_cnt  out  32  mispredictions (optional feature).

Behaviour:
- Decode encodings:
  - BEQ=000100, BNE=000101, BLEZ=000110, BGTZ=000111, REGIMM=000001.
  - REGIMM rt values: BLTZ=00000, BGEZ=00001, BLTZAL=10000, BGEZAL=10001.
  - Any other op/rt gives is_branch_d=0, taken_d=0, link_d=0.
- Condition rules, using sign bit a_d[WIDTH-1]:
  - BEQ: a==b. BNE: a!=b.
  - BGTZ: sign=0 and a!=0. BLEZ: sign=1 or a==0.
  - BGEZ/BGEZAL: sign=0. BLTZ/BLTZAL: sign=1.
- is_branch_d, taken_d, link_d and mispredict_d are combinational, zero latency.
- Index: idx = pc[IDX_W+1:2]; PC bits [1:0] are ignored.
- Counter states: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken. pred_taken_f = counter[idx_f][1].
- Update pipeline:
  - Capture at a rising edge when valid_d & is_branch_d & ~stall_d & ~flush_d: upd_v=1, upd_idx=idx_d, upd_taken=taken_d. Otherwise upd_v=0.
  - Apply at the next edge: taken increments saturating at 11; not-taken decrements saturating at 00.
  - Total latency from decode to counter change is 2 edges.
- Bypass: if upd_v=1 and idx_f==upd_idx, pred_taken_f uses the post-update value. This removes the one-cycle hazard.
- Back-to-back branches to the same index: each captures independently. The second update is computed from the already-applied first value, so no update is lost.
- Stall/flush asserted on the capture edge: nothing is captured. Asserting them while upd_v=1 does not cancel the pending apply.
- Reset:
  - All counters to 01; upd_v=0; counters of the optional feature to 0.
  - pred_taken_f=0 for every pc_f from the cycle after the reset edge.
  - Reset mid-operation drops any pending update.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - branch_cnt increments on each capture edge.
  - mispred_cnt increments on each edge where mispredict_d=1.
  - Both saturate at 32'hFFFFFFFF and clear on rst.
- Undefined: both outputs are constant 0 and no counter registers exist. All other behaviour is identical.

Test Plan:
- Pure compare, valid_d=0:
  - op=BEQ, a=b=32'h5 -> taken_d=1.
  - op=BGTZ, a=0 -> taken_d=0.
  - op=BLEZ, a=32'h80000000 -> taken_d=1.
  - op=REGIMM, rt=10001, a=7 -> taken_d=1, link_d=1.
  - op=000000 -> is_branch_d=0, taken_d=0.
- Training, pc_d=pc_f=0x0040_0010, three taken BEQs in consecutive cycles with pred_d=0:
  - Counter goes 01->10->11->11.
  - pred_taken_f=1 in the cycle after the first capture (via bypass).
  - mispredict_d=1 on all three.
- Saturation at 00: from reset, four not-taken BNEs at one PC -> counter 00, pred_taken_f=0, no wrap to 11.
- Stall/flush:
  - Taken branch with stall_d=1 for 2 cycles, then 0 -> exactly one update and one mispredict pulse.
  - Taken branch with flush_d=1 -> no update, mispredict_d=0.
- Aliasing and reset with BHT_DEPTH=64:
  - pc 0x0000_0000 and 0x0000_0100 share index 0, so training one changes the other's prediction.
  - rst in the cycle after capture -> counter reads 01, branch_cnt=0.
- With BRANCH_STATS_EN: 5 branches with 2 mispredictions -> branch_cnt=5, mispred_cnt=2. Without the macro, both read 0.

Source files
------------

// File: rtl/branch_cmp_bht_if.sv
// Fetch-lookup and decode-resolve signals of branch_cmp_bht, bundled as one interface.
// master drives the fetch/decode inputs; slave is the resolver/predictor.
interface branch_cmp_bht_if #(
   parameter int WIDTH = 32
);
   logic [31:0]      pc_f;
   logic             pred_taken_f;
   logic             valid_d;
   logic             stall_d;
   logic             flush_d;
   logic [31:0]      pc_d;
   logic [5:0]       op_d;
   logic [4:0]       rt_d;
   logic [WIDTH-1:0] a_d;
   logic [WIDTH-1:0] b_d;
   logic             pred_d;
   logic             is_branch_d;
   logic             taken_d;
   logic             link_d;
   logic             mispredict_d;
   logic [31:0]      branch_cnt;
   logic [31:0]      mispred_cnt;

   modport master (
      output pc_f, valid_d, stall_d, flush_d, pc_d, op_d, rt_d, a_d, b_d, pred_d,
      input  pred_taken_f, is_branch_d, taken_d, link_d, mispredict_d,
             branch_cnt, mispred_cnt
   );

   modport slave (
      input  pc_f, valid_d, stall_d, flush_d, pc_d, op_d, rt_d, a_d, b_d, pred_d,
      output pred_taken_f, is_branch_d, taken_d, link_d, mispredict_d,
             branch_cnt, mispred_cnt
   );
endinterface

// File: rtl/branch_cmp_bht.sv
// Decode-stage MIPS branch resolver with a bimodal 2-bit BHT and a one-cycle update pipeline.
// Optional branch/mispredict statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_cmp_bht #(
   parameter int WIDTH     = 32,
   parameter int BHT_DEPTH = 64
) (
   input logic             clk,
   input logic             rst,
   branch_cmp_bht_if.slave bus
);
   localparam int IDX_W = $clog2(BHT_DEPTH);

   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [4:0] RT_BLTZ   = 5'b00000;
   localparam logic [4:0] RT_BGEZ   = 5'b00001;
   localparam logic [4:0] RT_BLTZAL = 5'b10000;
   localparam logic [4:0] RT_BGEZAL = 5'b10001;

   function automatic logic [1:0] sat_next(input logic [1:0] ctr, input logic taken);
      if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
      else       return (ctr == 2'b00) ? ctr : ctr - 2'b01;
   endfunction

   logic             is_branch;
   logic             taken;
   logic             link;
   logic             a_neg;
   logic             a_zero;
   logic             a_eq_b;
   logic             capture;
   logic             mispredict;

   logic [1:0]       bht [BHT_DEPTH];
   logic             upd_v;
   logic [IDX_W-1:0] upd_idx;
   logic             upd_taken;
   logic [1:0]       upd_next;
   logic [IDX_W-1:0] idx_f;
   logic [IDX_W-1:0] idx_d;
   logic [1:0]       ctr_f;

   assign a_neg  = bus.a_d[WIDTH-1];
   assign a_zero = (bus.a_d == '0);
   assign a_eq_b = (bus.a_d == bus.b_d);

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      is_branch = 1'b0;
      taken     = 1'b0;
      link      = 1'b0;
      case (bus.op_d)
         OP_BEQ:  begin is_branch = 1'b1; taken = a_eq_b;            end
         OP_BNE:  begin is_branch = 1'b1; taken = ~a_eq_b;           end
         OP_BLEZ: begin is_branch = 1'b1; taken = a_neg | a_zero;    end
         OP_BGTZ: begin is_branch = 1'b1; taken = ~a_neg & ~a_zero;  end
         OP_REGIMM: begin
            case (bus.rt_d)
               RT_BLTZ:   begin is_branch = 1'b1; taken = a_neg;  end
               RT_BGEZ:   begin is_branch = 1'b1; taken = ~a_neg; end
               RT_BLTZAL: begin is_branch = 1'b1; taken = a_neg;  link = 1'b1; end
               RT_BGEZAL: begin is_branch = 1'b1; taken = ~a_neg; link = 1'b1; end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign capture    = bus.valid_d & is_branch & ~bus.stall_d & ~bus.flush_d;
   assign mispredict = capture & (taken != bus.pred_d);

   assign bus.is_branch_d  = is_branch;
   assign bus.taken_d      = taken;
   assign bus.link_d       = link;
   assign bus.mispredict_d = mispredict;

   assign idx_f    = bus.pc_f[IDX_W+1:2];
   assign idx_d    = bus.pc_d[IDX_W+1:2];
   assign upd_next = sat_next(bht[upd_idx], upd_taken);

   // Forward the pending update so fetch never sees a stale counter.
   assign ctr_f            = (upd_v && (idx_f == upd_idx)) ? upd_next : bht[idx_f];
   assign bus.pred_taken_f = ctr_f[1];

   // NOTE: the table is small flop storage, so it is reset to weak not-taken like any other state; a RAM-backed table could not be.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
         upd_v     <= 1'b0;
         upd_idx   <= '0;
         upd_taken <= 1'b0;
      end else begin
         if (upd_v) bht[upd_idx] <= upd_next;
         upd_v     <= capture;
         upd_idx   <= idx_d;
         upd_taken <= taken;
      end
   end

`ifdef BRANCH_STATS_EN
   logic [31:0] branch_cnt_q;
   logic [31:0] mispred_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (capture && (branch_cnt_q != '1))     branch_cnt_q  <= branch_cnt_q + 32'd1;
         if (mispredict && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
   end

   assign bus.branch_cnt  = branch_cnt_q;
   assign bus.mispred_cnt = mispred_cnt_q;
`else
   assign bus.branch_cnt  = '0;
   assign bus.mispred_cnt = '0;
`endif

   // PC bits outside the table index do not take part in prediction.
   logic unused_pc;
   assign unused_pc = &{1'b0, bus.pc_f[31:IDX_W+2], bus.pc_f[1:0],
                        bus.pc_d[31:IDX_W+2], bus.pc_d[1:0]};
endmodule

// File: tb/tb_branch_cmp_bht.sv
// Bench for branch_cmp_bht: decode vector table, hand-written BHT sequences, and
// random traffic against a behavioural counter-table model (honours BRANCH_STATS_EN).
module tb_branch_cmp_bht;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   branch_cmp_bht_if #(.WIDTH(32)) bus ();

   branch_cmp_bht #(.WIDTH(32), .BHT_DEPTH(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model state: plain integer counters plus one pending update.
   int     ref_ctr [64];
   bit     pend_v;
   int     pend_idx;
   bit     pend_tk;
   longint ref_bcnt;
   longint ref_mcnt;

   logic        obs_pred;
   logic        obs_mis;
   logic [31:0] obs_bcnt;
   logic [31:0] obs_mcnt;

   typedef struct {
      logic [5:0]  op;
      logic [4:0]  rt;
      logic [31:0] a;
      logic [31:0] b;
      logic        br;
      logic        tk;
      logic        lk;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int pc_idx(input logic [31:0] pc);
      return int'((pc >> 2) & 32'd63);
   endfunction

   task automatic ref_decode(input logic [5:0] op, input logic [4:0] rt, input logic [31:0] a,
                             input logic [31:0] b, output logic br, output logic tk, output logic lk);
      int sa;
      sa = $signed(a);
      br = 1'b0; tk = 1'b0; lk = 1'b0;
      if (op == OP_BEQ)       begin br = 1; tk = (a == b); end
      else if (op == OP_BNE)  begin br = 1; tk = (a != b); end
      else if (op == OP_BLEZ) begin br = 1; tk = (sa <= 0); end
      else if (op == OP_BGTZ) begin br = 1; tk = (sa > 0);  end
      else if (op == OP_REGIMM && (rt == 5'd0 || rt == 5'd16)) begin br = 1; tk = (sa < 0);  lk = rt[4]; end
      else if (op == OP_REGIMM && (rt == 5'd1 || rt == 5'd17)) begin br = 1; tk = (sa >= 0); lk = rt[4]; end
   endtask

   function automatic int bumped(input int c, input bit tk);
      if (tk) return (c < 3) ? c + 1 : 3;
      return (c > 0) ? c - 1 : 0;
   endfunction

   // Prediction = counter value as it stands once any in-flight update has landed.
   function automatic logic ref_pred(input int i);
      int c;
      c = ref_ctr[i];
      if (pend_v && pend_idx == i) c = bumped(c, pend_tk);
      return c >= 2;
   endfunction

   function automatic logic [31:0] ref_stat(input longint n);
`ifdef BRANCH_STATS_EN
      return (n > 64'hFFFFFFFF) ? 32'hFFFFFFFF : n[31:0];
`else
      return (n == n) ? 32'd0 : 32'd0;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) ref_ctr[i] = 1;
      pend_v = 0; pend_idx = 0; pend_tk = 0;
      ref_bcnt = 0; ref_mcnt = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.valid_d = 1'b0; bus.stall_d = 1'b0; bus.flush_d = 1'b0;
      @(posedge clk);
      model_reset();
   endtask

   task automatic step(input logic v, input logic st, input logic fl, input logic [31:0] pcd,
                       input logic [5:0] op, input logic [4:0] rt, input logic [31:0] a,
                       input logic [31:0] b, input logic pd, input logic [31:0] pcf);
      logic ebr, etk, elk, cap, emis;
      @(negedge clk);
      rst = 1'b0;
      bus.valid_d = v; bus.stall_d = st; bus.flush_d = fl; bus.pc_d = pcd;
      bus.op_d = op; bus.rt_d = rt; bus.a_d = a; bus.b_d = b; bus.pred_d = pd; bus.pc_f = pcf;
      #1;
      ref_decode(op, rt, a, b, ebr, etk, elk);
      cap  = v & ebr & ~st & ~fl;
      emis = cap & (etk != pd);
      check("is_branch_d", bus.is_branch_d, ebr);
      check("taken_d", bus.taken_d, etk);
      check("link_d", bus.link_d, elk);
      check("mispredict_d", bus.mispredict_d, emis);
      check("pred_taken_f", bus.pred_taken_f, ref_pred(pc_idx(pcf)));
      check("branch_cnt", bus.branch_cnt, ref_stat(ref_bcnt));
      check("mispred_cnt", bus.mispred_cnt, ref_stat(ref_mcnt));
      obs_pred = bus.pred_taken_f; obs_mis = bus.mispredict_d;
      obs_bcnt = bus.branch_cnt;   obs_mcnt = bus.mispred_cnt;
      @(posedge clk);
      if (pend_v) ref_ctr[pend_idx] = bumped(ref_ctr[pend_idx], pend_tk);
      pend_v   = cap;
      pend_idx = pc_idx(pcd);
      pend_tk  = etk;
      if (cap)  ref_bcnt++;
      if (emis) ref_mcnt++;
   endtask

   task automatic idle(input logic [31:0] pcf);
      step(1'b0, 1'b0, 1'b0, 32'h0, 6'h0, 5'h0, 32'h0, 32'h0, 1'b0, pcf);
   endtask

   vec_t vecs [8];

   initial begin
      logic [31:0] pc_t;
      int          pulses;
      logic [31:0] pcs [5];
      logic [5:0]  ops [7];
      logic [4:0]  rts [5];

      bus.pc_f = '0; bus.valid_d = 0; bus.stall_d = 0; bus.flush_d = 0; bus.pc_d = '0;
      bus.op_d = '0; bus.rt_d = '0; bus.a_d = '0; bus.b_d = '0; bus.pred_d = 0;
      model_reset();
      repeat (2) @(posedge clk);

      // Reset state: weak not-taken everywhere, statistics cleared.
      idle(32'h0040_0010);
      check("reset_pred", obs_pred, 1'b0);
      check("reset_bcnt", obs_bcnt, 32'd0);
      idle(32'h0000_00FC);

      // Pure compare table, valid_d=0.
      vecs[0] = '{OP_BEQ,    5'd0,  32'h5,        32'h5,        1, 1, 0};
      vecs[1] = '{OP_BGTZ,   5'd0,  32'h0,        32'h0,        1, 0, 0};
      vecs[2] = '{OP_BLEZ,   5'd0,  32'h8000_0000, 32'h0,       1, 1, 0};
      vecs[3] = '{OP_REGIMM, 5'd17, 32'h7,        32'h0,        1, 1, 1};
      vecs[4] = '{6'h00,     5'd0,  32'h3,        32'h3,        0, 0, 0};
      vecs[5] = '{OP_BNE,    5'd0,  32'h1,        32'h2,        1, 1, 0};
      vecs[6] = '{OP_REGIMM, 5'd16, 32'h7,        32'h0,        1, 0, 1};
      vecs[7] = '{OP_REGIMM, 5'd2,  32'hFFFF_FFFF, 32'h0,       0, 0, 0};
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 1'b0, 32'h0, vecs[i].op, vecs[i].rt, vecs[i].a, vecs[i].b, 1'b0, 32'h0);
         @(negedge clk);
         bus.valid_d = 1'b0;
         #1;
         check($sformatf("vec%0d_is_branch", i), bus.is_branch_d, vecs[i].br);
         check($sformatf("vec%0d_taken", i), bus.taken_d, vecs[i].tk);
         check($sformatf("vec%0d_link", i), bus.link_d, vecs[i].lk);
      end

      // Training: three taken BEQs, bypass makes the first update visible immediately.
      pc_t = 32'h0040_0010;
      step(1, 0, 0, pc_t, OP_BEQ, 5'd0, 32'h9, 32'h9, 1'b0, pc_t);
      check("train1_pred", obs_pred, 1'b0);
      check("train1_mis", obs_mis, 1'b1);
      step(1, 0, 0, pc_t, OP_BEQ, 5'd0, 32'h9, 32'h9, 1'b0, pc_t);
      check("train2_bypass_pred", obs_pred, 1'b1);
      check("train2_mis", obs_mis, 1'b1);
      step(1, 0, 0, pc_t, OP_BEQ, 5'd0, 32'h9, 32'h9, 1'b0, pc_t);
      check("train3_mis", obs_mis, 1'b1);
      idle(pc_t);
      check("train_sat11_pred", obs_pred, 1'b1);
      // 11 -> 11 -> 10 -> 01 : two not-taken steps must leave it predicting not-taken.
      step(1, 0, 0, pc_t, OP_BEQ, 5'd0, 32'h1, 32'h1, 1'b1, pc_t);
      step(1, 0, 0, pc_t, OP_BNE, 5'd0, 32'h1, 32'h1, 1'b1, pc_t);
      step(1, 0, 0, pc_t, OP_BNE, 5'd0, 32'h1, 32'h1, 1'b1, pc_t);
      idle(pc_t);
      check("train_down_pred", obs_pred, 1'b0);

      // Saturation at 00.
      do_reset();
      pc_t = 32'h0000_0040;
      repeat (4) step(1, 0, 0, pc_t, OP_BNE, 5'd0, 32'h3, 32'h3, 1'b0, pc_t);
      idle(pc_t);
      check("sat00_pred", obs_pred, 1'b0);
      step(1, 0, 0, pc_t, OP_BEQ, 5'd0, 32'h3, 32'h3, 1'b0, pc_t);
      idle(pc_t);
      check("sat00_nowrap", obs_pred, 1'b0);

      // Stall for two cycles, then release: one update, one mispredict pulse.
      do_reset();
      pc_t = 32'h0000_0080;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         step(1, (i < 2), 0, pc_t, OP_BEQ, 5'd0, 32'h4, 32'h4, 1'b0, pc_t);
         pulses += int'(obs_mis);
      end
      check("stall_pulses", pulses, 1);
      step(1, 0, 0, pc_t, OP_BNE, 5'd0, 32'h4, 32'h4, 1'b1, pc_t);
      idle(pc_t);
      check("stall_one_update", obs_pred, 1'b0);

      // Flush: nothing captured, no mispredict.
      do_reset();
      step(1, 0, 1, pc_t, OP_BEQ, 5'd0, 32'h4, 32'h4, 1'b0, pc_t);
      check("flush_mis", obs_mis, 1'b0);
      idle(pc_t);
      idle(pc_t);
      check("flush_no_update", obs_pred, 1'b0);

      // Aliasing: 0x000 and 0x100 share index 0.
      do_reset();
      step(1, 0, 0, 32'h0000_0000, OP_BGTZ, 5'd0, 32'h1, 32'h0, 1'b0, 32'h0000_0100);
      idle(32'h0000_0100);
      check("alias_pred", obs_pred, 1'b1);

      // Reset on the apply edge drops the pending update.
      do_reset();
      step(1, 0, 0, pc_t, OP_BEQ, 5'd0, 32'h4, 32'h4, 1'b0, pc_t);
      do_reset();
      idle(pc_t);
      check("rst_drop_pred", obs_pred, 1'b0);
      check("rst_drop_bcnt", obs_bcnt, 32'd0);

      // Statistics: five branches, two mispredicted.
      do_reset();
      step(1, 0, 0, 32'h200, OP_BEQ,    5'd0, 32'h1, 32'h1, 1'b1, 32'h0);
      step(1, 0, 0, 32'h204, OP_BNE,    5'd0, 32'h1, 32'h1, 1'b0, 32'h0);
      step(1, 0, 0, 32'h208, OP_BEQ,    5'd0, 32'h2, 32'h2, 1'b0, 32'h0);
      step(1, 0, 0, 32'h20C, OP_BGTZ,   5'd0, 32'h5, 32'h0, 1'b1, 32'h0);
      step(1, 0, 0, 32'h210, OP_REGIMM, 5'd0, 32'h1, 32'h0, 1'b1, 32'h0);
      idle(32'h0);
`ifdef BRANCH_STATS_EN
      check("stats_bcnt", obs_bcnt, 32'd5);
      check("stats_mcnt", obs_mcnt, 32'd2);
`else
      check("stats_bcnt", obs_bcnt, 32'd0);
      check("stats_mcnt", obs_mcnt, 32'd0);
`endif

      // Random traffic against the model.
      pcs[0] = 32'h0040_0010; pcs[1] = 32'h0040_0014; pcs[2] = 32'h0000_0100;
      pcs[3] = 32'h0000_0000; pcs[4] = 32'h0000_00FC;
      ops[0] = OP_BEQ; ops[1] = OP_BNE; ops[2] = OP_BLEZ; ops[3] = OP_BGTZ;
      ops[4] = OP_REGIMM; ops[5] = 6'h00; ops[6] = 6'h23;
      rts[0] = 5'd0; rts[1] = 5'd1; rts[2] = 5'd16; rts[3] = 5'd17; rts[4] = 5'd3;
      for (int n = 0; n < 600; n++) begin
         logic [31:0] ra, rb, rpcd, rpcf;
         if ($urandom_range(0, 149) == 0) do_reset();
         case ($urandom_range(0, 3))
            0:       ra = 32'h0;
            1:       ra = 32'h8000_0000 | $urandom_range(0, 15);
            2:       ra = $urandom_range(1, 20);
            default: ra = $urandom;
         endcase
         rb   = ($urandom_range(0, 1) == 1) ? ra : $urandom;
         rpcd = ($urandom_range(0, 4) == 0) ? ($urandom & 32'hFFFF_FFFC) : pcs[$urandom_range(0, 4)];
         rpcf = ($urandom_range(0, 2) == 0) ? rpcd : pcs[$urandom_range(0, 4)];
         step($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
              rpcd, ops[$urandom_range(0, 6)], rts[$urandom_range(0, 4)], ra, rb,
              1'($urandom_range(0, 1)), rpcf);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
